// File: rtl/minimac_rxsched_pkg.sv
// Shared constants for the minimac RX slot scheduler: slot states and CSR offsets.
package minimac_rxsched_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [4:0] OFS_DONE      = 5'h00;
    localparam logic [4:0] OFS_SLOT_BASE = 5'h01;
    localparam logic [4:0] OFS_OVR       = 5'h1F;
    localparam int         STRIDE        = 3;

    // field: 0 = state, 1 = base address, 2 = byte count
    function automatic logic [4:0] slot_ofs(input int slot, input int field);
        return 5'(int'(OFS_SLOT_BASE) + STRIDE * slot + field);
    endfunction

endpackage

// File: rtl/minimac_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
module minimac_rr_pick #(
    parameter  int SLOTS = 4,
    localparam int PTR_W = $clog2(SLOTS)
) (
    input  logic [SLOTS-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [SLOTS-1:0] gnt_o,
    output logic             found_o
);

    always_comb begin
        gnt_o   = '0;
        found_o = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= SLOTS) j = j - SLOTS;
            if (!found_o && req_i[j]) begin
                gnt_o[j] = 1'b1;
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/minimac_rxslot_sched.sv
// RX slot scheduler: CSR-armed slots granted one at a time to the minimac RX engine.
// Optional overrun counter at offset 0x1F enabled by MINIMAC_RXSCHED_OVERRUN_EN.
module minimac_rxslot_sched
    import minimac_rxsched_pkg::*;
#(
    parameter logic [3:0] csr_addr = 4'h0,
    parameter int         SLOTS    = 4,
    parameter int         ADR_W    = 30,
    parameter int         CNT_W    = 11
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [13:0]      csr_a,
    input  logic             csr_we,
    input  logic [31:0]      csr_di,
    output logic [31:0]      csr_do,
    output logic             irq_rx,
    output logic             rx_valid,
    output logic [ADR_W-1:0] rx_adr,
    input  logic             rx_resetcount,
    input  logic             rx_incrcount,
    input  logic             rx_endframe
);

    localparam int              PTR_W   = $clog2(SLOTS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       st_q   [SLOTS];
    logic [1:0]       st_d   [SLOTS];
    logic [ADR_W-1:0] base_q [SLOTS];
    logic [CNT_W-1:0] cnt_q  [SLOTS];
    logic [CNT_W-1:0] cnt_d  [SLOTS];

    logic [PTR_W-1:0] ptr_q, busy_idx_q, gnt_idx;
    logic             rx_valid_q, irq_q;
    logic [ADR_W-1:0] rx_adr_q;
    logic [31:0]      csr_do_q, rdata;

    logic             csr_sel;
    logic [4:0]       ofs;
    logic [SLOTS-1:0] st_we, base_we, ready_vec, done_vec, gnt_oh;
    logic             found, grant_ok, cpu_abort, end_ok;
    logic             unused_bits;

    assign csr_sel     = (csr_a[13:10] == csr_addr);
    assign ofs         = csr_a[4:0];
    assign unused_bits = ^{csr_a[9:5], csr_di};

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < SLOTS; i++) begin
            st_we[i]     = csr_sel && csr_we && (ofs == slot_ofs(i, 0));
            base_we[i]   = csr_sel && csr_we && (ofs == slot_ofs(i, 1));
            ready_vec[i] = (st_q[i] == ST_READY);
            done_vec[i]  = (st_q[i] == ST_DONE);
            if (gnt_oh[i]) gnt_idx = PTR_W'(i);
        end
    end

    minimac_rr_pick #(.SLOTS(SLOTS)) u_pick (
        .req_i   (ready_vec),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt_oh),
        .found_o (found)
    );

    // A CPU abort of the slot being picked, or of the BUSY slot, takes priority.
    assign grant_ok  = found && !rx_valid_q && !(st_we[gnt_idx] && csr_di[1:0] == ST_EMPTY);
    assign cpu_abort = rx_valid_q && st_we[busy_idx_q] && csr_di[1:0] == ST_EMPTY;
    assign end_ok    = rx_valid_q && rx_endframe && !cpu_abort;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (st_we[i] && ((st_q[i] == ST_EMPTY && csr_di[1:0] == ST_READY) ||
                             (st_q[i] != ST_EMPTY && csr_di[1:0] == ST_EMPTY)))
                st_d[i] = csr_di[1:0];
            if (grant_ok && gnt_idx == PTR_W'(i)) st_d[i] = ST_BUSY;
            if (end_ok && busy_idx_q == PTR_W'(i)) st_d[i] = ST_DONE;
            if (rx_valid_q && busy_idx_q == PTR_W'(i)) begin
                if (rx_resetcount && rx_incrcount) cnt_d[i] = CNT_W'(1);
                else if (rx_resetcount)            cnt_d[i] = '0;
                else if (rx_incrcount && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

`ifdef MINIMAC_RXSCHED_OVERRUN_EN
    logic [15:0] ovr_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)                                ovr_q <= '0;
        else if (csr_sel && csr_we && ofs == OFS_OVR) ovr_q <= '0;
        else if (rx_resetcount && !rx_valid_q && ovr_q != 16'hFFFF) ovr_q <= ovr_q + 16'd1;
    end
`endif

    always_comb begin
        rdata = '0;
        if (ofs == OFS_DONE) rdata[SLOTS-1:0] = done_vec;
        for (int i = 0; i < SLOTS; i++) begin
            if (ofs == slot_ofs(i, 0)) rdata[1:0]       = st_q[i];
            if (ofs == slot_ofs(i, 1)) rdata[ADR_W-1:0] = base_q[i];
            if (ofs == slot_ofs(i, 2)) rdata[CNT_W-1:0] = cnt_q[i];
        end
`ifdef MINIMAC_RXSCHED_OVERRUN_EN
        if (ofs == OFS_OVR) rdata[15:0] = ovr_q;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                st_q[i]   <= ST_EMPTY;
                base_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            ptr_q      <= '0;
            busy_idx_q <= '0;
            rx_valid_q <= 1'b0;
            rx_adr_q   <= '0;
            irq_q      <= 1'b0;
            csr_do_q   <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                if (base_we[i] && st_q[i] != ST_BUSY) base_q[i] <= csr_di[ADR_W-1:0];
            end
            if (grant_ok) begin
                rx_valid_q <= 1'b1;
                rx_adr_q   <= base_q[gnt_idx];
                busy_idx_q <= gnt_idx;
                ptr_q      <= (int'(gnt_idx) == SLOTS - 1) ? '0 : gnt_idx + PTR_W'(1);
            end else if (end_ok || cpu_abort) begin
                rx_valid_q <= 1'b0;
            end
            irq_q    <= |done_vec;
            csr_do_q <= csr_sel ? rdata : '0;
        end
    end

    assign csr_do   = csr_do_q;
    assign irq_rx   = irq_q;
    assign rx_valid = rx_valid_q;
    assign rx_adr   = rx_adr_q;

endmodule

// File: tb/tb_minimac_rxslot_sched.sv
// Directed self-checking bench for minimac_rxslot_sched (4 slots, csr_addr 0).
module tb_minimac_rxslot_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [13:0] csr_a = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_di = '0;
    logic [31:0] csr_do;
    logic        irq_rx, rx_valid;
    logic [29:0] rx_adr;
    logic        rx_resetcount = 1'b0, rx_incrcount = 1'b0, rx_endframe = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd;

    minimac_rxslot_sched dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
        .irq_rx(irq_rx), .rx_valid(rx_valid), .rx_adr(rx_adr),
        .rx_resetcount(rx_resetcount), .rx_incrcount(rx_incrcount),
        .rx_endframe(rx_endframe)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic csr_wr(input int ofs, input logic [31:0] data);
        csr_a  = {4'h0, 5'h0, 5'(ofs)};
        csr_we = 1'b1;
        csr_di = data;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input int ofs, output logic [31:0] data);
        csr_a  = {4'h0, 5'h0, 5'(ofs)};
        csr_we = 1'b0;
        tick();
        data = csr_do;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_irq", 32'(irq_rx), 0);
        chk("rst_csr_do", csr_do, 0);
        chk("rst_adr", 32'(rx_adr), 0);
        sys_rst = 1'b1;
        tick();
        csr_rd(1, rd);  chk("rst_st0", rd, 0);

        // slots 0 and 1 armed; slot 0 granted two cycles after its READY write
        csr_wr(2, 32'h100);
        csr_wr(5, 32'h200);
        csr_wr(1, 1);
        chk("lat_not_yet", 32'(rx_valid), 0);
        csr_wr(4, 1);
        chk("g0_valid", 32'(rx_valid), 1);
        chk("g0_adr", 32'(rx_adr), 32'h100);

        rx_resetcount = 1'b1; tick(); rx_resetcount = 1'b0;
        rx_incrcount = 1'b1; repeat (60) tick(); rx_incrcount = 1'b0;
        rx_endframe = 1'b1; tick(); rx_endframe = 1'b0;
        chk("ef_valid_drop", 32'(rx_valid), 0);
        chk("ef_irq_lat", 32'(irq_rx), 0);
        tick();
        chk("ef_irq", 32'(irq_rx), 1);
        chk("g1_valid", 32'(rx_valid), 1);
        chk("g1_adr", 32'(rx_adr), 32'h200);
        csr_rd(3, rd);  chk("cnt0_60", rd, 60);
        csr_rd(0, rd);  chk("done_map", rd, 32'h1);
        csr_rd(1, rd);  chk("st0_done", rd, 3);

        // pointer now 2: arm slots 0 and 3 while slot 1 is BUSY
        csr_wr(1, 0);
        csr_wr(1, 1);
        csr_wr(11, 32'h300);
        csr_wr(10, 1);
        chk("held_busy", 32'(rx_adr), 32'h200);
        rx_endframe = 1'b1; tick(); rx_endframe = 1'b0;
        tick();
        chk("rr_first3", 32'(rx_adr), 32'h300);
        rx_endframe = 1'b1; tick(); rx_endframe = 1'b0;
        tick();
        chk("rr_then0", 32'(rx_adr), 32'h100);
        chk("rr_then0_v", 32'(rx_valid), 1);

        // abort collides with endframe: CPU wins
        csr_wr(4, 0);
        csr_wr(10, 0);
        tick();
        chk("irq_clear", 32'(irq_rx), 0);
        csr_a = {4'h0, 5'h0, 5'd1}; csr_we = 1'b1; csr_di = 0; rx_endframe = 1'b1;
        tick();
        csr_we = 1'b0; rx_endframe = 1'b0;
        chk("abort_valid", 32'(rx_valid), 0);
        tick();
        chk("abort_irq", 32'(irq_rx), 0);
        csr_rd(1, rd);  chk("abort_st0", rd, 0);

        // saturation on slot 2
        csr_wr(8, 32'h222);
        csr_wr(7, 1);
        tick();
        chk("g2_adr", 32'(rx_adr), 32'h222);
        csr_wr(8, 32'h999);
        csr_rd(8, rd);  chk("base_busy_wr", rd, 32'h222);
        rx_incrcount = 1'b1; repeat (2100) tick(); rx_incrcount = 1'b0;
        csr_rd(9, rd);  chk("cnt_sat", rd, 2047);
        rx_resetcount = 1'b1; rx_incrcount = 1'b1; tick();
        rx_resetcount = 1'b0; rx_incrcount = 1'b0;
        csr_rd(9, rd);  chk("cnt_both", rd, 1);
        csr_wr(7, 0);
        chk("abort2_valid", 32'(rx_valid), 0);
        csr_wr(7, 3);
        csr_rd(7, rd);  chk("illegal_wr", rd, 0);
        csr_a = {4'h1, 5'h0, 5'd8}; tick();
        chk("unselected", csr_do, 0);
        csr_rd(30, rd); chk("unmapped", rd, 0);

        // resetcount while idle
        rx_resetcount = 1'b1; repeat (3) tick(); rx_resetcount = 1'b0;
`ifdef MINIMAC_RXSCHED_OVERRUN_EN
        csr_rd(31, rd); chk("ovr_3", rd, 3);
        csr_wr(31, 0);
        csr_rd(31, rd); chk("ovr_clr", rd, 0);
`else
        csr_rd(31, rd); chk("ovr_absent", rd, 0);
`endif

        // reset mid-frame; pointer is 3
        csr_wr(4, 1);
        tick();
        chk("g1b_adr", 32'(rx_adr), 32'h200);
        rx_endframe = 1'b1; tick(); rx_endframe = 1'b0;
        tick();
        chk("pre_irq", 32'(irq_rx), 1);
        csr_wr(1, 1);
        tick();
        chk("pre_valid", 32'(rx_valid), 1);
        rx_incrcount = 1'b1; repeat (5) tick(); rx_incrcount = 1'b0;
        csr_rd(4, rd);  chk("pre_csr_do", rd, 3);
        #2 sys_rst = 1'b0;
        #1;
        chk("arst_valid", 32'(rx_valid), 0);
        chk("arst_irq", 32'(irq_rx), 0);
        chk("arst_csr_do", csr_do, 0);
        tick();
        sys_rst = 1'b1;
        tick();
        for (int s = 0; s < 4; s++) begin
            csr_rd(1 + 3 * s, rd);
            chk($sformatf("post_st%0d", s), rd, 0);
        end
        chk("post_valid", 32'(rx_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/minimac_rxslot_sched.md
Name: minimac_rxslot_sched

Overview:
- Receive-buffer slot scheduler for the minimac RX path.
- Owns N receive slots, each with a state, a base word address and a byte count.
- Software arms slots through the CSR bus. The block grants one armed slot at a time to the RX engine via rx_valid/rx_adr and tracks the RX engine's count/endframe strobes.
- Raises irq_rx while any slot holds a completed frame. Sits between the CSR bus and the minimac RX engine, replacing the RX-slot logic of the control interface.

Parameters:
- csr_addr, 4'h0, CSR block select compared against csr_a[13:10]
- SLOTS, 4, number of RX slots (legal 2..8)
- ADR_W, 30, slot base word-address width
- CNT_W, 11, byte-count width (max frame 2047 bytes)

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous reset, active-low
- csr_a  in  14  CSR word address
- csr_we  in  1  CSR write enable
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data, registered
- irq_rx  out  1  level: any slot in DONE
- rx_valid  out  1  a slot is granted to the RX engine
- rx_adr  out  ADR_W  base word address of the granted slot
- rx_resetcount  in  1  frame start: zero the granted slot's count
- rx_incrcount  in  1  one byte stored in the granted slot
- rx_endframe  in  1  frame complete in the granted slot

Behaviour:
- Reset (sys_rst low, async):
  - all slot states EMPTY, base addresses 0, counts 0
  - rx_valid=0, rx_adr=0, csr_do=0, irq_rx=0
  - round-robin pointer = slot 0
- Slot state encoding: EMPTY=0, READY=1, BUSY=2, DONE=3.
- CSR select is csr_a[13:10]==csr_addr; offset is csr_a[4:0].
- Register map:
  - 0x00 (RO): DONE bitmap in bits [SLOTS-1:0]
  - 1+3i: state of slot i (RW, bits[1:0])
  - 2+3i: base address of slot i (RW)
  - 3+3i: count of slot i (RO)
  - 0x1F: overrun counter (see Optional Feature)
  - unmapped offsets read 0
- csr_do latency: one cycle after the address is presented; 0 when the block is not selected.
- Legal CPU state writes: EMPTY->READY, DONE->EMPTY, READY->EMPTY, BUSY->EMPTY.
  - BUSY->EMPTY aborts the frame.
  - All other written values are ignored.
  - A base-address write to a BUSY slot is ignored.
- Grant: when no slot is BUSY and at least one is READY:
  - pick the first READY slot at or after the round-robin pointer, wrapping
  - mark it BUSY; rx_valid=1 and rx_adr=its base on the next cycle
  - pointer advances to the granted slot +1, mod SLOTS
  - latency from a CSR write of READY to rx_valid is 2 cycles
- While BUSY:
  - rx_resetcount sets count=0
  - rx_incrcount sets count+1, saturating at 2^CNT_W-1
  - if both strobes occur in the same cycle, count=1
- rx_endframe: BUSY->DONE; rx_valid=0 the next cycle. A new grant is possible one cycle after that.
- A CPU BUSY->EMPTY write drops rx_valid the next cycle. If rx_endframe arrives in the same cycle, the CPU write wins: the slot goes EMPTY and irq_rx is not raised.
- Strobes arriving while rx_valid=0 are ignored, except for the overrun counter.
- irq_rx is registered and follows the OR of DONE slots with 1-cycle latency.
- rx_adr holds its last value while rx_valid=0.

Optional Feature:
- Macro: MINIMAC_RXSCHED_OVERRUN_EN.
- Defined:
  - a 16-bit saturating counter at offset 0x1F increments on each rx_resetcount seen while rx_valid=0
  - any CSR write to 0x1F clears it
  - if a clear and an increment occur in the same cycle, the result is 0
- Undefined: offset 0x1F reads 0, writes are ignored, and no counter flops exist.

Decomposition:
- Package minimac_rxsched_pkg holds:
  - slot-state localparams (EMPTY/READY/BUSY/DONE)
  - register offsets (OFS_DONE=0, OFS_SLOT_BASE=1, OFS_OVR=5'h1F)
  - the stride constant 3
- One sub-module, minimac_rr_pick: combinational round-robin picker over a SLOTS-bit request vector and a pointer. Returns a one-hot grant and a found flag.

Test Plan:
- Arm slots 0 and 1 READY -> rx_valid=1 with rx_adr=base0 2 cycles later. Send resetcount plus 60 incrcount plus endframe -> slot0 DONE, count=60, irq_rx=1, then slot1 granted.
- Pointer at 2 with slots 0 and 3 READY -> slot 3 granted first, then slot 0.
- Write EMPTY to slot 0 in the same cycle as rx_endframe -> slot0 EMPTY, irq_rx stays 0, rx_valid=0 next cycle.
- Send 2100 incrcount -> count reads 2047; resetcount and incrcount together -> count=1.
- No slot READY, 3 rx_resetcount pulses -> with the macro, 0x1F reads 3, and a write clears it to 0; without the macro it reads 0.
- Assert sys_rst low mid-frame -> rx_valid, irq_rx and csr_do drop to 0 immediately, all slot states read EMPTY after reset is released.
